// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce filter: FSM state encoding and
// the width of the qualify counter.
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } dbf_state_e;

  function automatic int unsigned dbf_cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: clr_i has priority over inc_i and the count sticks at
// all-ones instead of wrapping.
module sat_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/debounce_filter.sv
// Glitch filter and edge detector for a synchronized level. Optional accepted-edge
// counter on edge_cnt_o is enabled by defining DEBOUNCE_FILTER_EDGE_CNT_EN.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int          RESET_VAL     = 0,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 data_i,
  output logic                 data_o,
  output logic                 rise_o,
  output logic                 fall_o,
`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
  output logic [CNT_WIDTH-1:0] edge_cnt_o,
`endif
  output logic                 busy_o
);

  localparam int unsigned QW = dbf_cnt_width(STABLE_CYCLES);
  localparam logic [QW-1:0] LAST = QW'(STABLE_CYCLES - 1);

  if ((STABLE_CYCLES < 1) || (RESET_VAL < 0) || (RESET_VAL > 1) || (CNT_WIDTH < 1))
  begin : g_bad_param
    $error("debounce_filter: STABLE_CYCLES must be >= 1, RESET_VAL 0 or 1, CNT_WIDTH >= 1");
  end

  dbf_state_e    state;
  logic [QW-1:0] cnt;
  logic          accept;

  // Acceptance is decoded combinationally so the edge counter updates on the
  // same edge as data_o.
  always_comb begin
    accept = 1'b0;
    if (en_i && (data_i != data_o)) begin
      accept = (state == QUALIFY) ? (cnt == LAST) : (STABLE_CYCLES == 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= STABLE;
      cnt    <= '0;
      data_o <= 1'(RESET_VAL);
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (!en_i) begin
        state  <= STABLE;
        cnt    <= '0;
        busy_o <= 1'b0;
      end else if (accept) begin
        state  <= STABLE;
        cnt    <= '0;
        busy_o <= 1'b0;
        data_o <= data_i;
        rise_o <= data_i;
        fall_o <= !data_i;
      end else begin
        case (state)
          STABLE: begin
            if (data_i != data_o) begin
              state  <= QUALIFY;
              cnt    <= QW'(1);
              busy_o <= 1'b1;
            end else begin
              cnt <= '0;
            end
          end
          QUALIFY: begin
            if (data_i == data_o) begin
              state  <= STABLE;
              cnt    <= '0;
              busy_o <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state  <= STABLE;
            cnt    <= '0;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
  sat_cnt #(
    .WIDTH(CNT_WIDTH)
  ) u_edge_cnt (
    .clk_i(clk_i),
    .clr_i(rst_i),
    .inc_i(accept),
    .cnt_o(edge_cnt_o)
  );
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Scoreboard bench for debounce_filter: stimulus pushes expected pulses, a
// monitor pops and compares them whenever the main instance pulses.
module tb_debounce_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic din = 1'b0;

  logic a_data, a_rise, a_fall, a_busy;
  logic b_data, b_rise, b_fall, b_busy;
  logic c_data, c_rise, c_fall, c_busy;
`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
  logic [1:0] a_cnt, b_cnt, c_cnt;
`endif

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int   edge_no;
    logic rise;
    logic fall;
    logic data;
    int   cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debounce_filter #(.STABLE_CYCLES(4), .RESET_VAL(0), .CNT_WIDTH(2)) u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din),
    .data_o(a_data), .rise_o(a_rise), .fall_o(a_fall),
`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
    .edge_cnt_o(a_cnt),
`endif
    .busy_o(a_busy));

  debounce_filter #(.STABLE_CYCLES(4), .RESET_VAL(1), .CNT_WIDTH(2)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din),
    .data_o(b_data), .rise_o(b_rise), .fall_o(b_fall),
`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
    .edge_cnt_o(b_cnt),
`endif
    .busy_o(b_busy));

  debounce_filter #(.STABLE_CYCLES(1), .RESET_VAL(0), .CNT_WIDTH(2)) u_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din),
    .data_o(c_data), .rise_o(c_rise), .fall_o(c_fall),
`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
    .edge_cnt_o(c_cnt),
`endif
    .busy_o(c_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns at #1 after posedge number e.
  task automatic at_edge(input int e);
    if (cyc > e) begin
      $display("FAIL at_edge: edge %0d already passed (now %0d)", e, cyc);
      $fatal(1);
    end
    while (cyc != e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int e, input logic r, input logic f, input logic d, input int c);
    exp_t x;
    x.edge_no = e; x.rise = r; x.fall = f; x.data = d; x.cnt = c;
    sb.push_back(x);
  endtask

  // Monitor: every pulse on the main instance must match the next expectation.
  always begin
    @(posedge clk);
    #1;
    if (a_rise || a_fall) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, a_rise, a_fall}, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("pulse_edge", cyc, x.edge_no);
        chk("pulse_rise", a_rise, x.rise);
        chk("pulse_fall", a_fall, x.fall);
        chk("pulse_data", a_data, x.data);
        chk("pulse_busy", a_busy, 0);
`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
        chk("pulse_edge_cnt", a_cnt, x.cnt);
`endif
      end
    end
  end

  initial begin
    int k;
    int sat_tbl[5] = '{1, 2, 3, 3, 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_data", a_data, 0);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_pulse", {a_rise, a_fall}, 0);
    chk("rst_b_data", b_data, 1);
    chk("rst_c_data", c_data, 0);
`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
    chk("rst_a_cnt", a_cnt, 0);
`endif
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Glitch of 3 samples is rejected
    din = 1'b1; k = cyc + 1;
    at_edge(k + 2);
    chk("glitch_busy_mid", a_busy, 1);
    chk("glitch_data_mid", a_data, 0);
    @(negedge clk); din = 1'b0;
    at_edge(k + 3);
    chk("glitch_busy_end", a_busy, 0);
    chk("glitch_data_end", a_data, 0);
    chk("c_fall_follow", c_fall, 1);
    chk("c_data_follow", c_data, 0);
    repeat (3) @(negedge clk);

    // Rise accepted after 4 stable samples
    din = 1'b1; k = cyc + 1;
    push(k + 3, 1'b1, 1'b0, 1'b1, 1);
    at_edge(k);
    chk("rise_busy_first", a_busy, 1);
    chk("rise_data_first", a_data, 0);
    chk("c_rise_pulse", c_rise, 1);
    chk("c_data_rise", c_data, 1);
    at_edge(k + 1);
    chk("c_rise_one_cycle", c_rise, 0);
    at_edge(k + 2);
    chk("rise_data_before", a_data, 0);
    at_edge(k + 3);
    chk("rise_data_after", a_data, 1);
    repeat (3) @(negedge clk);

    // Fall accepted
    din = 1'b0; k = cyc + 1;
    push(k + 3, 1'b0, 1'b1, 1'b0, 2);
    at_edge(k + 3);
    chk("fall_data_after", a_data, 0);
    repeat (3) @(negedge clk);

    // Enable drop aborts qualification; restart after re-enable
    din = 1'b1; k = cyc + 1;
    at_edge(k + 1);
    chk("en_busy_before", a_busy, 1);
    @(negedge clk); en = 1'b0;
    at_edge(k + 2);
    chk("en_busy_frozen", a_busy, 0);
    chk("en_data_frozen", a_data, 0);
    repeat (5) @(negedge clk);
    en = 1'b1;
    push(k + 10, 1'b1, 1'b0, 1'b1, 3);
    at_edge(k + 9);
    chk("en_busy_restart", a_busy, 1);
    chk("en_data_pending", a_data, 0);
    at_edge(k + 10);
    chk("en_data_after", a_data, 1);
    repeat (3) @(negedge clk);

    // Reset mid-qualification
    din = 1'b0; k = cyc + 1;
    at_edge(k + 1);
    chk("rstq_busy_before", a_busy, 1);
    @(negedge clk); rst = 1'b1;
    at_edge(k + 2);
    chk("rstq_a_data", a_data, 0);
    chk("rstq_a_busy", a_busy, 0);
    chk("rstq_a_pulse", {a_rise, a_fall}, 0);
    chk("rstq_b_data", b_data, 1);
`ifdef DEBOUNCE_FILTER_EDGE_CNT_EN
    chk("rstq_a_cnt", a_cnt, 0);
`endif
    @(negedge clk); rst = 1'b0;
    at_edge(k + 5);
    chk("rstq_b_busy", b_busy, 1);
    chk("rstq_b_hold", b_data, 1);
    at_edge(k + 6);
    chk("rstq_b_fall", b_data, 0);
    repeat (3) @(negedge clk);

    // Saturation of the edge counter over five accepted edges
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din = ~din; k = cyc + 1;
      push(k + 3, din, !din, din, sat_tbl[i]);
      repeat (7) @(negedge clk);
    end
    repeat (6) @(negedge clk);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
